sequenciador_multiciclo: RTL and testbench

SEQUENCIADOR_MULTICICLO -- requirements
Module: sequenciador_multiciclo

---
 rtl/sequenciador_multiciclo.sv | 164 ++++++++++++++++
 tb/tb_sequenciador_multiciclo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sequenciador_multiciclo.sv
// Multicycle instruction sequencer: IF/ID/EX/MEM/WB control FSM with retire counting,
// an illegal-opcode trap and a memory-wait timeout.
module sequenciador_multiciclo #(
    parameter int N_INSTR     = 7,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic [2:0]  estado,
    output logic        if_en,
    output logic        id_en,
    output logic        ex_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pc_write,
    output logic        mem_req,
    output logic        done,
    output logic [1:0]  err,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EX   = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_BAD  = 3'b101,
        ST_FIM  = 3'b110,
        ST_IDLE = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        CL_LOAD,
        CL_STORE,
        CL_ALU,
        CL_BRANCH
    } class_t;

    localparam int              WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t            state_q, state_d;
    class_t            class_q, class_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        err_q, err_d;

    logic        retire;
    logic [16:0] count_inc;
    logic        last_instr;

    assign count_inc  = {1'b0, count_q} + 17'd1;
    assign last_instr = (count_inc >= 17'(N_INSTR));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        class_d  = class_q;
        wait_d   = wait_q;
        count_d  = count_q;
        err_d    = err_q;
        retire   = 1'b0;
        if_en    = 1'b0;
        id_en    = 1'b0;
        ex_en    = 1'b0;
        mem_en   = 1'b0;
        wb_en    = 1'b0;
        mem_req  = 1'b0;
        done     = 1'b0;
        pc_write = 1'b0;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_IF;
            ST_IF: begin
                if_en   = 1'b1;
                state_d = ST_ID;
            end
            ST_ID: begin
                id_en   = 1'b1;
                state_d = ST_EX;
                case (opcode)
                    7'b0000011:             class_d = CL_LOAD;
                    7'b0100011:             class_d = CL_STORE;
                    7'b0110011, 7'b0010011: class_d = CL_ALU;
                    7'b1100011:             class_d = CL_BRANCH;
                    default: begin
                        state_d = ST_FIM;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_EX: begin
                ex_en = 1'b1;
                case (class_q)
                    CL_LOAD, CL_STORE: begin
                        state_d = ST_MEM;
                        wait_d  = '0;
                    end
                    CL_ALU:  state_d = ST_WB;
                    default: retire  = 1'b1;
                endcase
            end
            ST_MEM: begin
                mem_en  = 1'b1;
                mem_req = 1'b1;
                // A late acknowledge on the timeout cycle still completes the access.
                if (mem_ready) begin
                    if (class_q == CL_LOAD) state_d = ST_WB;
                    else                    retire  = 1'b1;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = ST_FIM;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB: begin
                wb_en  = 1'b1;
                retire = 1'b1;
            end
            ST_FIM: done = 1'b1;
            default: begin
                state_d = ST_FIM;
                err_d   = ERR_ILLEGAL;
            end
        endcase

        if (retire) begin
            pc_write = 1'b1;
            count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_d  = last_instr ? ST_FIM : ST_IF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            class_q <= CL_LOAD;
            wait_q  <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign estado      = state_q;
    assign err         = err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed self-checking bench for sequenciador_multiciclo: drives inputs on the falling
// edge and checks state/outputs 1 time unit later.
module tb_sequenciador_multiciclo;

    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EX   = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_FIM  = 3'b110;
    localparam logic [2:0] S_IDLE = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [6:0]  opcode;
    logic [2:0]  estado;
    logic        if_en, id_en, ex_en, mem_en, wb_en, pc_write, mem_req, done;
    logic [1:0]  err;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequenciador_multiciclo #(.N_INSTR(7), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .estado(estado), .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
        .wb_en(wb_en), .pc_write(pc_write), .mem_req(mem_req), .done(done), .err(err),
        .instr_count(instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [6:0] op, input logic mr);
        @(negedge clk);
        rst = r; start = s; opcode = op; mem_ready = mr;
        #1;
    endtask

    // Checks state plus every Moore output it implies, and the expected pc_write strobe.
    task automatic expect_st(input string tag, input logic [2:0] st, input logic pcw);
        logic [4:0] en;
        en = 5'b00000;
        case (st)
            S_IF:    en = 5'b10000;
            S_ID:    en = 5'b01000;
            S_EX:    en = 5'b00100;
            S_MEM:   en = 5'b00010;
            S_WB:    en = 5'b00001;
            default: en = 5'b00000;
        endcase
        check({tag, ".estado"}, 32'(estado), 32'(st));
        check({tag, ".enables"}, 32'({if_en, id_en, ex_en, mem_en, wb_en}), 32'(en));
        check({tag, ".pc_write"}, 32'(pc_write), 32'(pcw));
        check({tag, ".mem_req"}, 32'(mem_req), 32'(st == S_MEM));
        check({tag, ".done"}, 32'(done), 32'(st == S_FIM));
    endtask

    task automatic reset_start(input string tag, input logic [6:0] op);
        step(1'b1, 1'b0, op, 1'b0);
        step(1'b0, 1'b1, op, 1'b0);
        expect_st({tag, ".idle"}, S_IDLE, 1'b0);
        check({tag, ".count0"}, 32'(instr_count), 32'd0);
        check({tag, ".err0"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 7'd0; mem_ready = 1'b0;

        // Reset state, then IDLE holds without start
        step(1'b1, 1'b0, OP_ALU, 1'b0);
        step(1'b0, 1'b0, OP_ALU, 1'b0);
        expect_st("reset", S_IDLE, 1'b0);
        check("reset.count", 32'(instr_count), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        step(1'b0, 1'b0, OP_ALU, 1'b0);
        expect_st("idle_hold", S_IDLE, 1'b0);

        // ALU: IF, ID, EX, WB then back to IF
        reset_start("alu", OP_ALU);
        step(1'b0, 1'b0, OP_ALU, 1'b0); expect_st("alu.if", S_IF, 1'b0);
        step(1'b0, 1'b0, OP_ALU, 1'b0); expect_st("alu.id", S_ID, 1'b0);
        step(1'b0, 1'b0, OP_ALU, 1'b0); expect_st("alu.ex", S_EX, 1'b0);
        step(1'b0, 1'b0, OP_ALU, 1'b0); expect_st("alu.wb", S_WB, 1'b1);
        check("alu.count_wb", 32'(instr_count), 32'd0);
        step(1'b0, 1'b0, OP_ALU, 1'b0); expect_st("alu.next_if", S_IF, 1'b0);
        check("alu.count", 32'(instr_count), 32'd1);

        // LOAD with 3 wait cycles: 4 MEM cycles, 8 cycles total
        reset_start("load", OP_LOAD);
        step(1'b0, 1'b0, OP_LOAD, 1'b0); expect_st("load.if", S_IF, 1'b0);
        step(1'b0, 1'b0, OP_LOAD, 1'b0); expect_st("load.id", S_ID, 1'b0);
        step(1'b0, 1'b0, OP_LOAD, 1'b0); expect_st("load.ex", S_EX, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, OP_LOAD, 1'b0); expect_st($sformatf("load.mem_wait%0d", k), S_MEM, 1'b0);
        end
        step(1'b0, 1'b0, OP_LOAD, 1'b1); expect_st("load.mem_rdy", S_MEM, 1'b0);
        step(1'b0, 1'b0, OP_LOAD, 1'b0); expect_st("load.wb", S_WB, 1'b1);
        step(1'b0, 1'b0, OP_LOAD, 1'b0); expect_st("load.next_if", S_IF, 1'b0);
        check("load.count", 32'(instr_count), 32'd1);

        // Illegal opcode traps to FIM with err=01, no retire; start ignored
        reset_start("ill", OP_BAD);
        step(1'b0, 1'b0, OP_BAD, 1'b0); expect_st("ill.if", S_IF, 1'b0);
        step(1'b0, 1'b0, OP_BAD, 1'b0); expect_st("ill.id", S_ID, 1'b0);
        step(1'b0, 1'b1, OP_BAD, 1'b0); expect_st("ill.fim", S_FIM, 1'b0);
        check("ill.err", 32'(err), 32'd1);
        check("ill.count", 32'(instr_count), 32'd0);
        step(1'b0, 1'b0, OP_BAD, 1'b0); expect_st("ill.fim_hold", S_FIM, 1'b0);
        check("ill.err_hold", 32'(err), 32'd1);

        // STORE with mem_ready stuck low: 16 MEM cycles then timeout
        reset_start("sto_to", OP_STORE);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_to.if", S_IF, 1'b0);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_to.id", S_ID, 1'b0);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_to.ex", S_EX, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st($sformatf("sto_to.mem%0d", k), S_MEM, 1'b0);
        end
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_to.fim", S_FIM, 1'b0);
        check("sto_to.err", 32'(err), 32'd2);
        check("sto_to.count", 32'(instr_count), 32'd0);

        // STORE acknowledged on the timeout cycle: retires from MEM
        reset_start("sto_ok", OP_STORE);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_ok.if", S_IF, 1'b0);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_ok.id", S_ID, 1'b0);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_ok.ex", S_EX, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st($sformatf("sto_ok.mem%0d", k), S_MEM, 1'b0);
        end
        step(1'b0, 1'b0, OP_STORE, 1'b1); expect_st("sto_ok.mem_rdy", S_MEM, 1'b1);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("sto_ok.next_if", S_IF, 1'b0);
        check("sto_ok.count", 32'(instr_count), 32'd1);
        check("sto_ok.err", 32'(err), 32'd0);

        // Reset in the middle of a MEM wait, then restart
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("rmem.id", S_ID, 1'b0);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("rmem.ex", S_EX, 1'b0);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("rmem.mem0", S_MEM, 1'b0);
        step(1'b1, 1'b1, OP_STORE, 1'b1); expect_st("rmem.mem1", S_MEM, 1'b1);
        check("rmem.count_pre", 32'(instr_count), 32'd1);
        step(1'b0, 1'b1, OP_STORE, 1'b0); expect_st("rmem.idle", S_IDLE, 1'b0);
        check("rmem.count", 32'(instr_count), 32'd0);
        check("rmem.err", 32'(err), 32'd0);
        step(1'b0, 1'b0, OP_STORE, 1'b0); expect_st("rmem.restart_if", S_IF, 1'b0);

        // Seven BRANCHes: 3 cycles each, seventh retire halts
        reset_start("br", OP_BRANCH);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, OP_BRANCH, 1'b0); expect_st($sformatf("br%0d.if", i), S_IF, 1'b0);
            check($sformatf("br%0d.count", i), 32'(instr_count), 32'(i));
            step(1'b0, 1'b0, OP_BRANCH, 1'b0); expect_st($sformatf("br%0d.id", i), S_ID, 1'b0);
            step(1'b0, 1'b0, OP_BRANCH, 1'b0); expect_st($sformatf("br%0d.ex", i), S_EX, 1'b1);
        end
        step(1'b0, 1'b1, OP_BRANCH, 1'b0); expect_st("br.fim", S_FIM, 1'b0);
        check("br.count", 32'(instr_count), 32'd7);
        check("br.err", 32'(err), 32'd0);
        step(1'b0, 1'b1, OP_BRANCH, 1'b0); expect_st("br.fim_hold", S_FIM, 1'b0);
        check("br.count_hold", 32'(instr_count), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
